// File: rtl/cpu_req_driver.sv
// cpu_req_driver: CPU-side initiator for the memory controller's CPU port.
// Queues local requests, issues them one at a time and reports read data or a timeout.
module cpu_req_driver #(
  parameter int ADDR_MCTRL  = 32,
  parameter int DQ_BITS     = 8,
  parameter int BURST_L     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int RST_HOLD    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          i_cpu_ck,
  input  logic                          i_cpu_reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_cmd,
  input  logic [ADDR_MCTRL-1:0]         req_addr,
  input  logic [8*DQ_BITS-1:0]          req_wr_data,
  input  logic [BURST_L-1:0]            req_dm,
  output logic                          rsp_valid,
  output logic                          rsp_cmd,
  output logic [8*DQ_BITS-1:0]          rsp_rd_data,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic                          mc_reset,
  output logic [ADDR_MCTRL-1:0]         mc_addr,
  output logic                          mc_cmd,
  output logic [8*DQ_BITS-1:0]          mc_wr_data,
  output logic                          mc_valid,
  output logic                          mc_enable,
  output logic [BURST_L-1:0]            mc_dm,
  output logic [$clog2(BURST_L):0]      mc_burst,
  input  logic [8*DQ_BITS-1:0]          mc_rd_data,
  input  logic                          mc_data_rdy,
  input  logic                          mc_rd_data_valid
);
  localparam int DW = 8 * DQ_BITS;
  localparam int BW = $clog2(BURST_L) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_RST_HOLD = 3'd0,
    S_IDLE     = 3'd1,
    S_ISSUE    = 3'd2,
    S_GUARD    = 3'd3,
    S_WAIT_WR  = 3'd4,
    S_WAIT_RD  = 3'd5
  } state_e;

  typedef struct packed {
    logic                  cmd;
    logic [ADDR_MCTRL-1:0] addr;
    logic [DW-1:0]         data;
    logic [BURST_L-1:0]    dm;
  } req_t;

  state_e                state_q, state_d;
  req_t                  fifo_q [FIFO_DEPTH];
  req_t                  fifo_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  mc_reset_q, mc_reset_d;
  logic                  mc_enable_q, mc_enable_d;
  logic                  mc_valid_q, mc_valid_d;
  logic                  mc_cmd_q, mc_cmd_d;
  logic [ADDR_MCTRL-1:0] mc_addr_q, mc_addr_d;
  logic [DW-1:0]         mc_wr_data_q, mc_wr_data_d;
  logic [BURST_L-1:0]    mc_dm_q, mc_dm_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_cmd_q, rsp_cmd_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [DW-1:0]         rsp_rd_data_q, rsp_rd_data_d;
  logic                  push_s, pop_s, full_s, empty_s, ready_s;
  req_t                  head_s;

  // FIFO status; ready is held low while the controller is still in reset
  always_comb begin
    full_s  = (count_q == CW'(FIFO_DEPTH));
    empty_s = (count_q == '0);
    ready_s = (state_q != S_RST_HOLD) && !full_s;
    push_s  = req_valid && ready_s;
    head_s  = fifo_q[rd_ptr_q];
  end

  // FIFO storage, pointers and occupancy
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = {req_cmd, req_addr, req_wr_data, req_dm};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transaction FSM: next state, controller-side command and response
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    timer_d       = timer_q;
    mc_reset_d    = mc_reset_q;
    mc_enable_d   = mc_enable_q;
    mc_valid_d    = 1'b0;
    mc_cmd_d      = mc_cmd_q;
    mc_addr_d     = mc_addr_q;
    mc_wr_data_d  = mc_wr_data_q;
    mc_dm_d       = mc_dm_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_cmd_d     = rsp_cmd_q;
    rsp_rd_data_d = rsp_rd_data_q;
    pop_s         = 1'b0;
    case (state_q)
      S_RST_HOLD: begin
        if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
          hold_cnt_d  = '0;
          mc_reset_d  = 1'b0;
          mc_enable_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      S_IDLE: begin
        if (!empty_s && mc_data_rdy) begin
          pop_s        = 1'b1;
          mc_valid_d   = 1'b1;
          mc_cmd_d     = head_s.cmd;
          mc_addr_d    = head_s.addr;
          mc_wr_data_d = head_s.data;
          mc_dm_d      = head_s.dm;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_GUARD;
      end
      // Controller takes a cycle to drop mc_data_rdy after a command
      S_GUARD: begin
        timer_d = timer_q + TW'(1);
        if (mc_cmd_q) begin
          state_d = S_WAIT_WR;
        end else begin
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_WR: begin
        timer_d = timer_q + TW'(1);
        if (mc_data_rdy) begin
          rsp_valid_d = 1'b1;
          rsp_cmd_d   = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_cmd_d     = 1'b1;
          state_d       = S_IDLE;
        end else begin
          state_d = S_WAIT_WR;
        end
      end
      S_WAIT_RD: begin
        timer_d = timer_q + TW'(1);
        if (mc_rd_data_valid) begin
          rsp_valid_d   = 1'b1;
          rsp_cmd_d     = 1'b0;
          rsp_rd_data_d = mc_rd_data;
          state_d       = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_cmd_d     = 1'b0;
          state_d       = S_IDLE;
        end else begin
          state_d = S_WAIT_RD;
        end
      end
      default: begin
        hold_cnt_d  = '0;
        mc_reset_d  = 1'b1;
        mc_enable_d = 1'b0;
        state_d     = S_RST_HOLD;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_cpu_ck or negedge i_cpu_reset_n) begin
    if (!i_cpu_reset_n) begin
      state_q       <= S_RST_HOLD;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      hold_cnt_q    <= '0;
      timer_q       <= '0;
      mc_reset_q    <= 1'b1;
      mc_enable_q   <= 1'b0;
      mc_valid_q    <= 1'b0;
      mc_cmd_q      <= 1'b0;
      mc_addr_q     <= '0;
      mc_wr_data_q  <= '0;
      mc_dm_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_cmd_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      hold_cnt_q    <= hold_cnt_d;
      timer_q       <= timer_d;
      mc_reset_q    <= mc_reset_d;
      mc_enable_q   <= mc_enable_d;
      mc_valid_q    <= mc_valid_d;
      mc_cmd_q      <= mc_cmd_d;
      mc_addr_q     <= mc_addr_d;
      mc_wr_data_q  <= mc_wr_data_d;
      mc_dm_q       <= mc_dm_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_cmd_q     <= rsp_cmd_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rd_data_q <= rsp_rd_data_d;
    end
  end

  assign req_ready   = ready_s;
  assign busy        = (state_q != S_IDLE) || !empty_s;
  assign mc_reset    = mc_reset_q;
  assign mc_enable   = mc_enable_q;
  assign mc_valid    = mc_valid_q;
  assign mc_cmd      = mc_cmd_q;
  assign mc_addr     = mc_addr_q;
  assign mc_wr_data  = mc_wr_data_q;
  assign mc_dm       = mc_dm_q;
  assign mc_burst    = BW'(BURST_L);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_cmd     = rsp_cmd_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rd_data = rsp_rd_data_q;

endmodule

// File: tb/tb_cpu_req_driver.sv
// Bench for cpu_req_driver: scripted vectors, directed corner sequences and random traffic
// checked every cycle against a transaction-level model of the request/response contract.
module tb_cpu_req_driver;
  localparam int RST_HOLD = 16;
  localparam int TIMEOUT  = 1024;
  localparam int DEPTH    = 4;
  localparam int NTBL     = 7;

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  dm;
  } txn_t;

  typedef struct {
    txn_t        req;
    int          delay;
    logic [63:0] ret;
    logic        exp_cmd;
    logic        exp_to;
    logic [63:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_cmd = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wr_data = 64'd0;
  logic [7:0]  req_dm = 8'd0;
  logic        req_ready, rsp_valid, rsp_cmd, rsp_timeout, busy;
  logic [63:0] rsp_rd_data;
  logic        mc_reset, mc_cmd, mc_valid, mc_enable;
  logic [31:0] mc_addr;
  logic [63:0] mc_wr_data;
  logic [7:0]  mc_dm;
  logic [3:0]  mc_burst;
  logic [63:0] mc_rd_data = 64'd0;
  logic        mc_data_rdy = 1'b0, mc_rd_data_valid = 1'b0;

  cpu_req_driver dut (
    .i_cpu_ck(clk), .i_cpu_reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_dm(req_dm),
    .rsp_valid(rsp_valid), .rsp_cmd(rsp_cmd), .rsp_rd_data(rsp_rd_data),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .mc_reset(mc_reset), .mc_addr(mc_addr), .mc_cmd(mc_cmd), .mc_wr_data(mc_wr_data),
    .mc_valid(mc_valid), .mc_enable(mc_enable), .mc_dm(mc_dm), .mc_burst(mc_burst),
    .mc_rd_data(mc_rd_data), .mc_data_rdy(mc_data_rdy), .mc_rd_data_valid(mc_rd_data_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  txn_t        exp_q[$];
  txn_t        cur;
  bit          outstanding, base_rdy, rand_mode, have_issue;
  int          j, resp_delay, tbl_delay, hold_edges, noise_pct, issue_cnt;
  longint      cyc, last_issue_cyc;
  logic [63:0] last_rd, ret_data;
  vec_t        tbl[NTBL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    outstanding = 1'b0;
    j = 0;
    hold_edges = 0;
    last_rd = 64'd0;
    have_issue = 1'b0;
  endtask

  // One clock: drive controller side, predict from the contract, advance, compare, update
  task automatic cycle();
    bit          hold_ok, ready_pred, exp_push, exp_issue, exp_done, exp_to;
    txn_t        drv;
    logic [63:0] cap;
    mc_data_rdy      = base_rdy;
    mc_rd_data       = {$urandom, $urandom};
    mc_rd_data_valid = ($urandom_range(99) < noise_pct);
    if (outstanding && j == resp_delay) begin
      if (cur.cmd) begin
        mc_data_rdy = 1'b1;
      end else begin
        mc_rd_data_valid = 1'b1;
        mc_rd_data       = ret_data;
      end
    end
    hold_ok    = hold_edges >= RST_HOLD;
    ready_pred = hold_ok && (exp_q.size() < DEPTH);
    chk("req_ready", req_ready, ready_pred);
    drv.cmd = req_cmd; drv.addr = req_addr; drv.data = req_wr_data; drv.dm = req_dm;
    exp_push  = req_valid && ready_pred;
    exp_issue = hold_ok && !outstanding && exp_q.size() > 0 && mc_data_rdy;
    exp_done  = outstanding && j >= 2 && (cur.cmd ? mc_data_rdy : mc_rd_data_valid);
    exp_to    = outstanding && !exp_done && j == TIMEOUT;
    cap       = mc_rd_data;
    @(posedge clk); #1;
    cyc++;
    hold_edges++;
    chk("mc_reset", mc_reset, hold_edges < RST_HOLD);
    chk("mc_enable", mc_enable, hold_edges >= RST_HOLD);
    chk("mc_burst", mc_burst, 64'd8);
    chk("mc_valid", mc_valid, exp_issue);
    if (exp_issue) begin
      chk("mc_cmd", mc_cmd, exp_q[0].cmd);
      chk("mc_addr", mc_addr, exp_q[0].addr);
      chk("mc_wr_data", mc_wr_data, exp_q[0].data);
      chk("mc_dm", mc_dm, exp_q[0].dm);
      if (have_issue) chk("issue_spacing_ge4", (cyc - last_issue_cyc) >= 4, 1'b1);
      have_issue = 1'b1;
      last_issue_cyc = cyc;
    end
    chk("rsp_valid", rsp_valid, exp_done || exp_to);
    if (exp_done && !cur.cmd) last_rd = cap;
    if (exp_done || exp_to) begin
      chk("rsp_cmd", rsp_cmd, cur.cmd);
      chk("rsp_timeout", rsp_timeout, exp_to);
      chk("rsp_rd_data", rsp_rd_data, last_rd);
    end
    if (exp_push) exp_q.push_back(drv);
    if (exp_done || exp_to) outstanding = 1'b0;
    else if (outstanding) j++;
    if (exp_issue) begin
      cur = exp_q.pop_front();
      outstanding = 1'b1;
      j = 0;
      issue_cnt++;
      resp_delay = rand_mode ? int'($urandom_range(40, 2)) : tbl_delay;
    end
    chk("busy", busy, (hold_edges < RST_HOLD) || outstanding || (exp_q.size() > 0));
  endtask

  task automatic set_req(input logic c, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    req_cmd = c; req_addr = a; req_wr_data = d; req_dm = m;
  endtask

  initial begin
    bit got;
    tbl[0] = '{'{1'b1, 32'h40, 64'hA5A5_A5A5_A5A5_A5A5, 8'h01}, 5,    64'd0,                 1'b1, 1'b0, 64'd0};
    tbl[1] = '{'{1'b0, 32'h40, 64'd0, 8'h02},                  10,   64'h1122334455667788,  1'b0, 1'b0, 64'h1122334455667788};
    tbl[2] = '{'{1'b0, 32'h80, 64'd0, 8'h04},                  5000, 64'd0,                 1'b0, 1'b1, 64'h1122334455667788};
    tbl[3] = '{'{1'b1, 32'h1234, 64'hDEAD_BEEF_0BAD_F00D, 8'h80}, 2, 64'd0,                 1'b1, 1'b0, 64'h1122334455667788};
    tbl[4] = '{'{1'b0, 32'hFFFF_FFFC, 64'd0, 8'h10},           1024, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0, 64'hCAFE_F00D_1234_5678};
    tbl[5] = '{'{1'b0, 32'h8, 64'd0, 8'h20},                   1,    64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 64'hCAFE_F00D_1234_5678};
    tbl[6] = '{'{1'b1, 32'h10, 64'h5555_AAAA_5555_AAAA, 8'h40}, 1,   64'd0,                 1'b1, 1'b1, 64'hCAFE_F00D_1234_5678};
    cyc = 0; issue_cnt = 0; rand_mode = 1'b0; noise_pct = 0; base_rdy = 1'b0;
    tbl_delay = 3; ret_data = 64'd0; resp_delay = 0;
    model_reset();

    // Power-on reset and hold
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mc_reset", mc_reset, 1'b1);
    chk("rst_mc_enable", mc_enable, 1'b0);
    chk("rst_mc_valid", mc_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mc_addr", mc_addr, 64'd0);
    chk("rst_rsp_rd_data", rsp_rd_data, 64'd0);
    rst_n = 1'b1;
    model_reset();
    repeat (RST_HOLD + 2) cycle();
    chk("hold_done_ready", req_ready, 1'b1);

    // Table-driven single transactions
    for (int t = 0; t < NTBL; t++) begin
      set_req(tbl[t].req.cmd, tbl[t].req.addr, tbl[t].req.data, tbl[t].req.dm);
      tbl_delay = tbl[t].delay;
      ret_data  = tbl[t].ret;
      base_rdy  = 1'b1;
      req_valid = 1'b1;
      cycle();
      req_valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 1200 && !got; n++) begin
        cycle();
        if (mc_valid) base_rdy = 1'b0;
        if (rsp_valid) begin
          got = 1'b1;
          chk($sformatf("tbl%0d_rsp_cmd", t), rsp_cmd, tbl[t].exp_cmd);
          chk($sformatf("tbl%0d_rsp_timeout", t), rsp_timeout, tbl[t].exp_to);
          chk($sformatf("tbl%0d_rsp_rd_data", t), rsp_rd_data, tbl[t].exp_rd);
        end
      end
      if (!got) chk($sformatf("tbl%0d_rsp_seen", t), 1'b0, 1'b1);
    end

    // FIFO fill with controller not ready, then drain in order
    base_rdy = 1'b0; tbl_delay = 3;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 32'h100 + 32'(i * 16), {$urandom, $urandom}, 8'h01 << i);
      req_valid = 1'b1;
      if (i == 4) chk("fifo_full_ready", req_ready, 1'b0);
      cycle();
    end
    req_valid = 1'b0;
    issue_cnt = 0;
    base_rdy  = 1'b1;
    for (int n = 0; n < 200 && (outstanding || exp_q.size() > 0); n++) cycle();
    chk("fifo_issue_count", issue_cnt, 64'd4);
    chk("fifo_drained_busy", busy, 1'b0);

    // Reset while waiting on a read with two requests queued
    tbl_delay = 5000; base_rdy = 1'b1;
    set_req(1'b0, 32'h200, 64'd0, 8'h01); req_valid = 1'b1; cycle();
    set_req(1'b1, 32'h210, 64'h1, 8'h02); cycle();
    base_rdy = 1'b0;
    set_req(1'b1, 32'h220, 64'h2, 8'h04); cycle();
    req_valid = 1'b0;
    repeat (4) cycle();
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("midrst_mc_reset", mc_reset, 1'b1);
    chk("midrst_mc_enable", mc_enable, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    chk("midrst_mc_addr", mc_addr, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    base_rdy = 1'b1;
    repeat (RST_HOLD + 6) cycle();
    chk("post_reset_busy", busy, 1'b0);

    // Random traffic against the model
    rand_mode = 1'b1; noise_pct = 5;
    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(1) == 1);
      set_req(1'(($urandom_range(1))), $urandom, {$urandom, $urandom}, 8'h01 << $urandom_range(7));
      base_rdy = ($urandom_range(9) < 7);
      cycle();
    end
    req_valid = 1'b0; base_rdy = 1'b1;
    for (int n = 0; n < 3000 && (outstanding || exp_q.size() > 0); n++) cycle();
    chk("random_drained", outstanding || (exp_q.size() > 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
